// File: rtl/sobel_row_fetch_pkg.sv
// Shared definitions for the Sobel row fetcher.
// Contents:
//   - `NUM_SOBEL_ACCELERATORS / `SOBEL_IDATA_WIDTH defaults (overridable on the command line)
//   - cfg field widths, FSM state encodings
//   - cfg validity check and saturating increment helpers
// Optional feature macro used by the top: SOBEL_ROW_FETCH_PERF_EN.

`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 8
`endif

`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH ((`NUM_SOBEL_ACCELERATORS + 2) * 8)
`endif

package sobel_row_fetch_pkg;

  localparam int NUM_SOBEL_ACCELERATORS = `NUM_SOBEL_ACCELERATORS;
  localparam int SOBEL_IDATA_WIDTH      = `SOBEL_IDATA_WIDTH;

  localparam int CFG_CNT_W = 16;
  localparam int STATE_W   = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ  = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_EMIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  // A 3-row window needs at least three rows, and there must be a strip to walk.
  function automatic logic cfg_is_valid(input logic [CFG_CNT_W-1:0] num_rows,
                                        input logic [CFG_CNT_W-1:0] num_strips);
    return (num_rows >= 16'd3) && (num_strips != '0);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sobel_row_window.sv
// Three-row sliding window plus fill counter.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clr                   restart the fill count (row contents are kept)
//   shift_en, shift_data  push a new bottom row; rows move up by one
//   row1/row2/row3        oldest / middle / newest row
//   fill                  rows pushed since clr, saturating at 3

module sobel_row_window #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic [W-1:0] shift_data,
  output logic [W-1:0] row1,
  output logic [W-1:0] row2,
  output logic [W-1:0] row3,
  output logic [1:0]   fill
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row1 <= '0;
      row2 <= '0;
      row3 <= '0;
      fill <= '0;
    end else begin
      if (shift_en) begin
        row1 <= row2;
        row2 <= row3;
        row3 <= shift_data;
      end
      // Rows from a previous strip stay in place; only fill gates their use.
      if (clr) begin
        fill <= '0;
      end else if (shift_en && (fill != 2'd3)) begin
        fill <= fill + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sobel_row_fetch.sv
// Sobel row fetcher: walks the image strip-major, fetching NUM_ACC+2 pixel
// row segments, and presents each full 3-row window with valid/ready.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   ctl2srow_*                        start pulse and image configuration
//   srow2ctl_busy/done/cfg_err        status towards the controller
//   srow2smem_rd_req/rd_addr          single-outstanding read request
//   smem2srow_rd_valid/rd_data        read return
//   srow2sacc_row1/2/3_data, valid    window towards the accelerator core
//   sacc2srow_ready                   window accepted
//   srow2dbg_state                    current FSM state
//   srow2ctl_busy/stall_cycles        perf counters (SOBEL_ROW_FETCH_PERF_EN only)
// Handshake: a window transfers on a cycle where valid && ready are both high;
// valid stays high with stable rows until then, and ready alone does nothing.
// Outputs are registered one cycle behind the FSM state, so the first valid
// of a strip shows two cycles after its third read return, and done shows two
// cycles after a rejected start.

module sobel_row_fetch
  import sobel_row_fetch_pkg::*;
#(
  parameter int NUM_ACC     = NUM_SOBEL_ACCELERATORS,
  parameter int IDATA_WIDTH = SOBEL_IDATA_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ctl2srow_start,
  input  logic [ADDR_WIDTH-1:0]  ctl2srow_base_addr,
  input  logic [ADDR_WIDTH-1:0]  ctl2srow_row_stride,
  input  logic [CFG_CNT_W-1:0]   ctl2srow_num_rows,
  input  logic [CFG_CNT_W-1:0]   ctl2srow_num_strips,
  output logic                   srow2ctl_busy,
  output logic                   srow2ctl_done,
  output logic                   srow2ctl_cfg_err,
`ifdef SOBEL_ROW_FETCH_PERF_EN
  output logic [31:0]            srow2ctl_busy_cycles,
  output logic [31:0]            srow2ctl_stall_cycles,
`endif
  output logic                   srow2smem_rd_req,
  output logic [ADDR_WIDTH-1:0]  srow2smem_rd_addr,
  input  logic                   smem2srow_rd_valid,
  input  logic [IDATA_WIDTH-1:0] smem2srow_rd_data,
  output logic [IDATA_WIDTH-1:0] srow2sacc_row1_data,
  output logic [IDATA_WIDTH-1:0] srow2sacc_row2_data,
  output logic [IDATA_WIDTH-1:0] srow2sacc_row3_data,
  output logic                   srow2sacc_valid,
  input  logic                   sacc2srow_ready,
  output logic [STATE_W-1:0]     srow2dbg_state
);

  logic [STATE_W-1:0]    state, next_state;
  logic [CFG_CNT_W-1:0]  cfg_rows, cfg_strips;
  logic [ADDR_WIDTH-1:0] cfg_stride;
  logic [CFG_CNT_W-1:0]  row_cnt, strip_cnt;
  // Addresses are kept incrementally: strip_base = base + strip*NUM_ACC,
  // row_addr = strip_base + row*stride, both wrapping modulo 2^ADDR_WIDTH.
  logic [ADDR_WIDTH-1:0] strip_base, row_addr;
  logic [1:0]            fill;

  logic start_acc, cfg_ok, fetch_ret, handshake, strip_end, last_strip, new_strip;

  assign cfg_ok     = cfg_is_valid(ctl2srow_num_rows, ctl2srow_num_strips);
  assign start_acc  = (state == ST_IDLE) && ctl2srow_start;
  assign fetch_ret  = (state == ST_WAIT) && smem2srow_rd_valid;
  assign handshake  = (state == ST_EMIT) && srow2sacc_valid && sacc2srow_ready;
  assign strip_end  = !(row_cnt < cfg_rows);
  assign last_strip = ((strip_cnt + 16'd1) == cfg_strips);
  assign new_strip  = handshake && strip_end && !last_strip;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (ctl2srow_start) next_state = cfg_ok ? ST_REQ : ST_DONE;
      ST_REQ:  next_state = ST_WAIT;
      // fill is the pre-shift count: 2 means this return completes the window.
      ST_WAIT: if (smem2srow_rd_valid) next_state = (fill >= 2'd2) ? ST_EMIT : ST_REQ;
      ST_EMIT: if (handshake) next_state = (strip_end && last_strip) ? ST_DONE : ST_REQ;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cfg_rows         <= '0;
      cfg_strips       <= '0;
      cfg_stride       <= '0;
      row_cnt          <= '0;
      strip_cnt        <= '0;
      strip_base       <= '0;
      row_addr         <= '0;
      srow2ctl_busy    <= 1'b0;
      srow2ctl_done    <= 1'b0;
      srow2ctl_cfg_err <= 1'b0;
      srow2sacc_valid  <= 1'b0;
    end else begin
      state           <= next_state;
      // Busy drops in the same cycle done rises.
      srow2ctl_busy   <= (next_state != ST_IDLE);
      srow2ctl_done   <= (state == ST_DONE);
      srow2sacc_valid <= (state == ST_EMIT) && !handshake;
      if (start_acc) begin
        srow2ctl_cfg_err <= !cfg_ok;
        cfg_rows         <= ctl2srow_num_rows;
        cfg_strips       <= ctl2srow_num_strips;
        cfg_stride       <= ctl2srow_row_stride;
        row_cnt          <= '0;
        strip_cnt        <= '0;
        strip_base       <= ctl2srow_base_addr;
        row_addr         <= ctl2srow_base_addr;
      end
      if (fetch_ret) begin
        row_cnt  <= row_cnt + 16'd1;
        row_addr <= row_addr + cfg_stride;
      end
      if (new_strip) begin
        strip_cnt  <= strip_cnt + 16'd1;
        row_cnt    <= '0;
        strip_base <= strip_base + ADDR_WIDTH'(NUM_ACC);
        row_addr   <= strip_base + ADDR_WIDTH'(NUM_ACC);
      end
    end
  end

  assign srow2smem_rd_req  = (state == ST_REQ);
  assign srow2smem_rd_addr = srow2smem_rd_req ? row_addr : '0;
  assign srow2dbg_state    = state;

  sobel_row_window #(
    .W (IDATA_WIDTH)
  ) u_window (
    .clk        (clk),
    .rst_n      (reset_n),
    .clr        (start_acc || new_strip),
    .shift_en   (fetch_ret),
    .shift_data (smem2srow_rd_data),
    .row1       (srow2sacc_row1_data),
    .row2       (srow2sacc_row2_data),
    .row3       (srow2sacc_row3_data),
    .fill       (fill)
  );

`ifdef SOBEL_ROW_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srow2ctl_busy_cycles  <= '0;
      srow2ctl_stall_cycles <= '0;
    end else if (start_acc) begin
      srow2ctl_busy_cycles  <= '0;
      srow2ctl_stall_cycles <= '0;
    end else begin
      if (srow2ctl_busy) begin
        srow2ctl_busy_cycles <= sat_inc32(srow2ctl_busy_cycles);
      end
      if ((state == ST_WAIT) || ((state == ST_EMIT) && !sacc2srow_ready)) begin
        srow2ctl_stall_cycles <= sat_inc32(srow2ctl_stall_cycles);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sobel_row_fetch.sv
// Bench for sobel_row_fetch: directed steps plus randomized jobs, checked
// against an address/window reference model built from the image geometry.
// Optional feature macro: SOBEL_ROW_FETCH_PERF_EN.

module tb_sobel_row_fetch;
  localparam int NUM_ACC = 8;
  localparam int IW      = 80;
  localparam int AW      = 32;
  localparam int WIN_W   = 3 * IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic          start;
  logic [AW-1:0] base_addr, row_stride;
  logic [15:0]   num_rows, num_strips;
  logic          busy, done, cfg_err, rd_req, rd_valid, valid, ready;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data, row1, row2, row3;
  logic [2:0]    dbg_state;
`ifdef SOBEL_ROW_FETCH_PERF_EN
  logic [31:0]   busy_cycles, stall_cycles;
`endif

  sobel_row_fetch dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .ctl2srow_start      (start),
    .ctl2srow_base_addr  (base_addr),
    .ctl2srow_row_stride (row_stride),
    .ctl2srow_num_rows   (num_rows),
    .ctl2srow_num_strips (num_strips),
    .srow2ctl_busy       (busy),
    .srow2ctl_done       (done),
    .srow2ctl_cfg_err    (cfg_err),
`ifdef SOBEL_ROW_FETCH_PERF_EN
    .srow2ctl_busy_cycles  (busy_cycles),
    .srow2ctl_stall_cycles (stall_cycles),
`endif
    .srow2smem_rd_req    (rd_req),
    .srow2smem_rd_addr   (rd_addr),
    .smem2srow_rd_valid  (rd_valid),
    .smem2srow_rd_data   (rd_data),
    .srow2sacc_row1_data (row1),
    .srow2sacc_row2_data (row2),
    .srow2sacc_row3_data (row3),
    .srow2sacc_valid     (valid),
    .sacc2srow_ready     (ready),
    .srow2dbg_state      (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_seed = 32'h0;
  int          lat_min = 1, lat_max = 1;
  bit          glitch_en = 1'b0;
  int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  function automatic logic [IW-1:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A ^ mem_seed, a * 32'd3 + 32'h1357, a[15:0] ^ 16'hC3C3};
  endfunction

  function automatic logic [31:0] pix_addr(input logic [31:0] b, input logic [31:0] st,
                                           input int s, input int r);
    return b + 32'(r) * st + 32'(s * NUM_ACC);
  endfunction

  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] got_addr_q[$];

  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        rd_valid = 1'b1;
        rd_data  = mem_word(pend_addr);
        pend     = 1'b0;
      end
    end else if (glitch_en && ($urandom_range(0, 3) == 0)) begin
      // No read outstanding, so the fetcher is not waiting: this must be ignored.
      rd_valid = 1'b1;
      rd_data  = {$urandom, $urandom, 16'($urandom)};
    end
    if (rd_req) begin
      pend      = 1'b1;
      pend_cnt  = $urandom_range(lat_min, lat_max);
      pend_addr = rd_addr;
      got_addr_q.push_back(rd_addr);
    end
  end

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  logic [WIN_W-1:0] got_win_q[$];
  int               done_cnt = 0;

  always @(negedge clk) begin
    if (valid && ready) got_win_q.push_back({row1, row2, row3});
    if (done) done_cnt = done_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [WIN_W-1:0] exp_q[$];
  logic [31:0]      exp_addr_q[$];
  int checks = 0, failures = 0;
  int a0, w0, d0;

  task automatic check(input string tag, input logic [WIN_W-1:0] obs,
                       input logic [WIN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic build_model(input int rows, input int strips,
                             input logic [31:0] b, input logic [31:0] st);
    exp_addr_q.delete();
    exp_q.delete();
    for (int s = 0; s < strips; s++) begin
      for (int r = 0; r < rows; r++) exp_addr_q.push_back(pix_addr(b, st, s, r));
      for (int r = 0; r + 2 < rows; r++)
        exp_q.push_back({mem_word(pix_addr(b, st, s, r)), mem_word(pix_addr(b, st, s, r + 1)),
                         mem_word(pix_addr(b, st, s, r + 2))});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [15:0] rows, input logic [15:0] strips,
                        input logic [31:0] b, input logic [31:0] st);
    a0 = got_addr_q.size();
    w0 = got_win_q.size();
    d0 = done_cnt;
    num_rows   = rows;
    num_strips = strips;
    base_addr  = b;
    row_stride = st;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    // Configuration must have been captured; scramble it.
    num_rows   = 16'($urandom);
    num_strips = 16'($urandom);
    base_addr  = $urandom;
    row_stride = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((done_cnt == d0) && (n < 5000)) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, WIN_W'(done_cnt != d0), WIN_W'(1));
    check({tag, "_busy_at_done"}, WIN_W'(busy), WIN_W'(0));
  endtask

  task automatic compare(input string tag);
    tick();
    tick();
    check({tag, "_nreads"}, WIN_W'(got_addr_q.size() - a0), WIN_W'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size(); i++)
      if (a0 + i < got_addr_q.size())
        check($sformatf("%s_addr%0d", tag, i), WIN_W'(got_addr_q[a0 + i]), WIN_W'(exp_addr_q[i]));
    check({tag, "_nwin"}, WIN_W'(got_win_q.size() - w0), WIN_W'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (w0 + i < got_win_q.size())
        check($sformatf("%s_win%0d", tag, i), got_win_q[w0 + i], exp_q[i]);
    check({tag, "_ndone"}, WIN_W'(done_cnt - d0), WIN_W'(1));
    check({tag, "_cfg_err"}, WIN_W'(cfg_err), WIN_W'(0));
  endtask

  task automatic run_job(input int rows, input int strips, input logic [31:0] b,
                         input logic [31:0] st, input int lmin, input int lmax,
                         input bit glitch, input int rmode, input string tag);
    lat_min    = lmin;
    lat_max    = lmax;
    glitch_en  = glitch;
    ready_mode = rmode;
    build_model(rows, strips, b, st);
    launch(16'(rows), 16'(strips), b, st);
    wait_done(tag);
    compare(tag);
  endtask

  task automatic bad_cfg(input logic [15:0] rows, input logic [15:0] strips, input string tag);
    glitch_en = 1'b0;
    launch(rows, strips, 32'h4000, 32'h80);
    check({tag, "_busy_c1"}, WIN_W'(busy), WIN_W'(1));
    check({tag, "_done_c1"}, WIN_W'(done), WIN_W'(0));
    tick();
    check({tag, "_done_c2"}, WIN_W'(done), WIN_W'(1));
    check({tag, "_busy_c2"}, WIN_W'(busy), WIN_W'(0));
    check({tag, "_cfg_err"}, WIN_W'(cfg_err), WIN_W'(1));
    tick();
    check({tag, "_done_c3"}, WIN_W'(done), WIN_W'(0));
    repeat (4) tick();
    check({tag, "_no_reads"}, WIN_W'(got_addr_q.size() - a0), WIN_W'(0));
    check({tag, "_cfg_err_sticky"}, WIN_W'(cfg_err), WIN_W'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    row_stride = '0;
    num_rows   = '0;
    num_strips = '0;
    mem_seed   = $urandom;
    repeat (3) tick();
    check("rst_busy", WIN_W'(busy), WIN_W'(0));
    check("rst_done", WIN_W'(done), WIN_W'(0));
    check("rst_cfg_err", WIN_W'(cfg_err), WIN_W'(0));
    check("rst_rd_req", WIN_W'({rd_req, rd_addr}), WIN_W'(0));
    check("rst_valid", WIN_W'(valid), WIN_W'(0));
    check("rst_rows", {row1, row2, row3}, WIN_W'(0));
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic single strip, latency 1.
    run_job(4, 1, 32'h1000, 32'h100, 1, 1, 1'b0, 1, "basic");
    // Two strips of three rows: second strip offset by NUM_ACC bytes.
    run_job(3, 2, 32'h1000, 32'h100, 1, 1, 1'b0, 1, "two_strips");

    // Back-pressure: ready held low for 10 cycles while a window is offered.
    lat_min = 2; lat_max = 2; glitch_en = 1'b0; ready_mode = 0;
    build_model(5, 1, 32'h2000, 32'h40);
    launch(16'd5, 16'd1, 32'h2000, 32'h40);
    begin
      int n = 0;
      while (!valid && (n < 200)) begin
        tick();
        n++;
      end
    end
    check("stall_valid_seen", WIN_W'(valid), WIN_W'(1));
    for (int k = 0; k < 10; k++) begin
      check($sformatf("stall_valid%0d", k), WIN_W'(valid), WIN_W'(1));
      check($sformatf("stall_rows%0d", k), {row1, row2, row3}, exp_q[0]);
      check($sformatf("stall_no_req%0d", k), WIN_W'(rd_req), WIN_W'(0));
      tick();
    end
`ifdef SOBEL_ROW_FETCH_PERF_EN
    check("perf_stall_ge10", WIN_W'(stall_cycles >= 32'd10), WIN_W'(1));
    check("perf_busy_gt_stall", WIN_W'(busy_cycles > stall_cycles), WIN_W'(1));
`endif
    ready_mode = 1;
    wait_done("stall");
    compare("stall");

    // Invalid configurations, then a valid start clears the sticky error.
    bad_cfg(16'd2, 16'd1, "rows2");
    bad_cfg(16'd5, 16'd0, "strips0");
    lat_min = 1; lat_max = 3; ready_mode = 1;
    build_model(4, 1, 32'h3000, 32'h20);
    launch(16'd4, 16'd1, 32'h3000, 32'h20);
    check("cfg_err_cleared", WIN_W'(cfg_err), WIN_W'(0));
    wait_done("after_err");
    compare("after_err");

    // Randomized jobs with variable latency, spurious returns and random ready.
    run_job(4, 2, 32'hFFFF_FF80, 32'h40, 1, 7, 1'b1, 2, "wrap");
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(3, 7), $urandom_range(1, 3), $urandom, 32'($urandom_range(1, 32'hFFFF)),
              1, 7, 1'b1, 2, $sformatf("rand%0d", j));

    // Reset while waiting on a read; the late response must be ignored.
    lat_min = 7; lat_max = 7; glitch_en = 1'b0; ready_mode = 1;
    launch(16'd6, 16'd1, 32'h5000, 32'h100);
    begin
      int n = 0;
      while ((got_addr_q.size() < a0 + 2) && (n < 200)) begin
        tick();
        n++;
      end
    end
    check("rstmid_req_seen", WIN_W'(got_addr_q.size() >= a0 + 2), WIN_W'(1));
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_busy", WIN_W'(busy), WIN_W'(0));
    check("rstmid_rows", {row1, row2, row3}, WIN_W'(0));
    check("rstmid_valid_req", WIN_W'({valid, rd_req, done}), WIN_W'(0));
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("rstmid_no_more_reads", WIN_W'(got_addr_q.size() - a0), WIN_W'(2));
    check("rstmid_late_ignored", {row1, row2, row3}, WIN_W'(0));
    check("rstmid_idle", WIN_W'({busy, valid, done}), WIN_W'(0));
    check("rstmid_no_windows", WIN_W'(got_win_q.size() - w0), WIN_W'(0));
    run_job(5, 2, 32'h6000, 32'h200, 1, 4, 1'b1, 2, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_row_fetch.md
Name: sobel_row_fetch

Overview:
- Producer side of the Sobel row interface: fetches input-image row segments from memory and drives the three row registers (row1/row2/row3) consumed by the Sobel accelerator core.
- Traverses the image strip-major. Each strip is NUM_ACC output pixels wide, so each fetch is NUM_ACC+2 input pixels.
- Walks down every row of a strip with a 3-row sliding window and presents each full window with a valid/ready handshake.

Parameters:
- NUM_ACC, default `NUM_SOBEL_ACCELERATORS (8): output pixels per window.
- IDATA_WIDTH, default `SOBEL_IDATA_WIDTH ((NUM_ACC+2)*8 = 80): bits per fetched row segment.
- ADDR_WIDTH, default 32: memory byte-address width.

Ports:
- clk, input, 1: clock; all state on rising edge.
- reset_n, input, 1: reset, asynchronous, active-low.
- ctl2srow_start, input, 1: one-cycle start pulse; ignored unless idle.
- ctl2srow_base_addr, input, ADDR_WIDTH: byte address of pixel (0,0).
- ctl2srow_row_stride, input, ADDR_WIDTH: bytes between vertically adjacent pixels.
- ctl2srow_num_rows, input, 16: image height in rows.
- ctl2srow_num_strips, input, 16: strips per image.
- srow2ctl_busy, output, 1: high from the cycle after an accepted start until done.
- srow2ctl_done, output, 1: one-cycle completion pulse.
- srow2ctl_cfg_err, output, 1: sticky; set when num_rows<3 or num_strips==0 at start; cleared by the next accepted start.
- srow2smem_rd_req, output, 1: one-cycle read request.
- srow2smem_rd_addr, output, ADDR_WIDTH: read address, valid with rd_req.
- smem2srow_rd_valid, input, 1: read data return; arbitrary latency ≥1 cycle.
- smem2srow_rd_data, input, IDATA_WIDTH: returned row segment; byte k = pixel k of the segment.
- srow2sacc_row1_data, output, IDATA_WIDTH: oldest (top) row of the window.
- srow2sacc_row2_data, output, IDATA_WIDTH: middle row.
- srow2sacc_row3_data, output, IDATA_WIDTH: newest (bottom) row.
- srow2sacc_valid, output, 1: window valid.
- sacc2srow_ready, input, 1: consumer accepts the window.

Behaviour:
- Reset values: all outputs 0, row registers 0, FSM in IDLE, counters 0.
- Captures all cfg inputs on the accepted start; later cfg changes are ignored until the next start.
- FSM states: IDLE, REQ, WAIT, EMIT, DONE.
  - IDLE -> on start with valid cfg: clear row_cnt, strip_cnt and fill, go to REQ. With invalid cfg: set cfg_err, go to DONE, no memory traffic.
  - REQ: rd_req=1 for exactly one cycle; rd_addr = base + row_cnt*row_stride + strip_cnt*NUM_ACC. Go to WAIT.
  - WAIT: on rd_valid, shift row1<=row2, row2<=row3, row3<=rd_data; row_cnt++; fill=min(fill+1,3). If fill is now 3, go to EMIT, else go to REQ.
  - EMIT: valid=1 with rows held stable until ready. On valid&&ready:
    - if row_cnt<num_rows, go to REQ;
    - else if strip_cnt==num_strips-1, go to DONE;
    - else strip_cnt++, row_cnt=0, fill=0, go to REQ.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Exactly one read outstanding. rd_valid outside WAIT is ignored.
- Windows per strip = num_rows-2. Total windows = (num_rows-2)*num_strips.
- Latency: first valid appears 2 cycles after the third rd_valid of a strip at the earliest (WAIT->EMIT registered).
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- Row registers are not cleared between strips. The fill counter guarantees stale data never reaches valid.
- ready while valid=0 has no effect. valid never drops without a handshake.
- Reset mid-operation: immediate return to reset values. An in-flight read response after reset is ignored because the FSM is in IDLE.

Optional Feature:
- Macro SOBEL_ROW_FETCH_PERF_EN.
- Defined: adds outputs srow2ctl_busy_cycles[31:0] and srow2ctl_stall_cycles[31:0].
  - busy_cycles counts cycles with busy=1.
  - stall_cycles counts WAIT cycles plus EMIT cycles with ready=0.
  - Both clear on accepted start, saturate at 0xFFFFFFFF, and hold after done.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines file (common_defines): FSM state encodings, `SOBEL_IDATA_WIDTH, `NUM_SOBEL_ACCELERATORS, cfg field widths.
- One sub-module: sobel_row_window (three IDATA_WIDTH shift registers plus fill counter, with shift-enable and clear). The FSM and address generation stay in the top.

Test Plan:
- num_rows=4, num_strips=1, base=0x1000, stride=0x100, memory latency 1 -> reads at 0x1000/0x1100/0x1200/0x1300; 2 windows, with row1/2/3 = rows 0/1/2 then 1/2/3; one done pulse.
- num_rows=3, num_strips=2, NUM_ACC=8 -> second strip reads 0x1008/0x1108/0x1208; exactly 2 windows total; fill restarts, so no window mixes strips.
- ready held 0 for 10 cycles during EMIT -> valid and row data stable, no rd_req issued; stall_cycles (with PERF_EN) includes those 10.
- num_rows=2 or num_strips=0 -> no rd_req; done 2 cycles after start; cfg_err=1; the next valid start clears it.
- Random memory latency 1-7 cycles and rd_valid glitches in IDLE/EMIT -> windows match the reference model, spurious returns ignored.
- reset_n asserted during WAIT with a response pending -> outputs 0 asynchronously; the late rd_valid is ignored; a new start runs cleanly.
